// File: rtl/display_7_segmentos.sv
// Purpose: registered 4-bit binary to seven-segment decoder (a..g), hex or dash above 9.
// Latency: 1 cycle from bin to decimal; one new digit accepted every cycle.
// Backpressure: none; the output simply follows the sampled input each edge.
module display_7_segmentos #(
   parameter bit ACTIVE_LOW = 1'b1,
   parameter bit HEX_MODE   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bin,
   output logic [0:6] decimal
);

   // Index 0 is segment a and index 6 is segment g, so the literal patterns below read a..g left to right.
   localparam logic [0:6] SEG_DASH = 7'b0000001;
   localparam logic [0:6] SEG_OFF  = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

   logic [0:6] glyph;
   logic [0:6] drive;

   // Logical glyph lookup (1 = lit), independent of board polarity.
   always_comb begin
      glyph = SEG_DASH;
      case (bin)
         4'd0:  glyph = 7'b1111110;
         4'd1:  glyph = 7'b0110000;
         4'd2:  glyph = 7'b1101101;
         4'd3:  glyph = 7'b1111001;
         4'd4:  glyph = 7'b0110011;
         4'd5:  glyph = 7'b1011011;
         4'd6:  glyph = 7'b1011111;
         4'd7:  glyph = 7'b1110000;
         4'd8:  glyph = 7'b1111111;
         4'd9:  glyph = 7'b1111011;
         4'd10: glyph = HEX_MODE ? 7'b1110111 : SEG_DASH;
         4'd11: glyph = HEX_MODE ? 7'b0011111 : SEG_DASH;
         4'd12: glyph = HEX_MODE ? 7'b1001110 : SEG_DASH;
         4'd13: glyph = HEX_MODE ? 7'b0111101 : SEG_DASH;
         4'd14: glyph = HEX_MODE ? 7'b1001111 : SEG_DASH;
         4'd15: glyph = HEX_MODE ? 7'b1000111 : SEG_DASH;
         default: glyph = SEG_DASH;
      endcase
   end

   // Map logical segments onto pin polarity (common-anode pins sink current to light).
   always_comb begin
      drive = ACTIVE_LOW ? ~glyph : glyph;
   end

   // Output register keeps the pins glitch-free; reset blanks the digit whatever bin holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         decimal <= SEG_OFF;
      end else begin
         decimal <= drive;
      end
   end

endmodule

// File: tb/tb_display_7_segmentos.sv
module tb_display_7_segmentos;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] bin;
   logic [0:6] dec_dflt;
   logic [0:6] dec_hex;

   int n_cmp = 0;
   int n_bad = 0;

   // Physical outputs expected from the default build (active-low, dash above 9).
   logic [6:0] dflt_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
      7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110
   };

   // Outputs expected from the active-high hex build.
   logic [6:0] hex_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
      7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   display_7_segmentos dut_dflt (
      .clk     (clk),
      .rst     (rst),
      .bin     (bin),
      .decimal (dec_dflt)
   );

   display_7_segmentos #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) dut_hex (
      .clk     (clk),
      .rst     (rst),
      .bin     (bin),
      .decimal (dec_hex)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   // Drive inputs away from the edge, then sample 1 time unit after it.
   task automatic apply(input logic [3:0] v, input logic r);
      @(negedge clk);
      bin = v;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bin = 4'd8;

      // Reset held for two edges with bin=8 must blank, not show 8.
      for (int i = 0; i < 2; i++) begin
         apply(4'd8, 1'b1);
         check($sformatf("reset_dflt_%0d", i), dec_dflt, 7'b1111111);
         check($sformatf("reset_hex_%0d", i), dec_hex, 7'b0000000);
      end

      // Full sweep; first edge after reset release already shows the decode.
      for (int v = 0; v < 16; v++) begin
         apply(v[3:0], 1'b0);
         check($sformatf("sweep_dflt_%0d", v), dec_dflt, dflt_tab[v]);
         check($sformatf("sweep_hex_%0d", v), dec_hex, hex_tab[v]);
      end

      // Mid-cycle wiggle 3 -> 7 -> 3 must never show up on the output.
      apply(4'd3, 1'b0);
      check("glitch_pre", dec_dflt, 7'b0000110);
      @(negedge clk);
      bin = 4'd7;
      #1;
      check("glitch_mid", dec_dflt, 7'b0000110);
      check("glitch_mid_hex", dec_hex, 7'b1111001);
      #1;
      bin = 4'd3;
      @(posedge clk);
      #1;
      check("glitch_edge", dec_dflt, 7'b0000110);
      apply(4'd3, 1'b0);
      check("steady_hold", dec_dflt, 7'b0000110);

      // Single-edge reset in the middle of a sweep.
      apply(4'd4, 1'b0);
      check("mid_pre_dflt", dec_dflt, 7'b1001100);
      apply(4'd5, 1'b1);
      check("mid_rst_dflt", dec_dflt, 7'b1111111);
      check("mid_rst_hex", dec_hex, 7'b0000000);
      apply(4'd6, 1'b0);
      check("mid_post_dflt", dec_dflt, 7'b0100000);
      check("mid_post_hex", dec_hex, 7'b1011111);
      apply(4'd7, 1'b0);
      check("mid_next_dflt", dec_dflt, 7'b0001111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_7_segmentos.md
# display_7_segmentos

Registered BCD/hex-to-seven-segment decoder. Converts a 4-bit binary digit into the seven segment drive lines of one display digit. Decimal digits 0–9 map to their standard glyphs; codes 10–15 show either hex glyphs or a dash, selected by parameter. The block sits between digit-producing logic and the board's segment pins. Its output is registered so the pins are glitch-free.

## Interface
Parameters:
- `ACTIVE_LOW`, default 1: 1 = a lit segment drives 0 (common-anode); 0 = a lit segment drives 1.
- `HEX_MODE`, default 0: 1 = codes 10–15 show A b C d E F; 0 = codes 10–15 show a dash (segment g only).

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `bin`, input, 4: binary digit to display, unsigned 0–15.
- `decimal`, output, 7, declared `[0:6]`: segment drive. `decimal[0]`=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g, in standard a–g layout (a top, clockwise, g middle).

## Operation
- Segment patterns in logical form (1 = lit), bit order a..g, i.e. `decimal[0]..decimal[6]`:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
- Codes 10–15 with `HEX_MODE`=1:
  - A = 1110111
  - b = 0011111
  - C = 1001110
  - d = 0111101
  - E = 1001111
  - F = 1000111
- Codes 10–15 with `HEX_MODE`=0: all show 0000001 (dash).
- Physical output = logical pattern when `ACTIVE_LOW`=0; bitwise inverse when `ACTIVE_LOW`=1.
- Decode is purely combinational from `bin`; the result is captured in a 7-bit output register.
- No other state, no enable, no handshake.

## Timing
- `decimal` is registered.
  - On each rising `clk` with `rst`=0, `decimal` takes the decode of the `bin` value sampled at that edge.
  - Latency is 1 cycle; throughput is one new digit per cycle.
- Reset:
  - On a rising `clk` with `rst`=1, `decimal` becomes "all segments off": 1111111 when `ACTIVE_LOW`=1, 0000000 when `ACTIVE_LOW`=0.
  - `bin` is ignored during reset.
- Reset mid-operation: the next edge blanks the display regardless of `bin`. The first edge after `rst` falls shows the decode of the `bin` sampled at that edge.
- Power-up, before the first reset edge: `decimal` is undefined. The register carries no initial value.
- `bin` changes between edges have no effect on the output until the next edge. There is no intermediate glitching on `decimal`.
- Consecutive identical `bin` values hold `decimal` steady.

## Test plan
- Reset, default parameters: hold `rst`=1 for 2 edges with `bin`=8 -> `decimal`=1111111 (blank, not "8").
- Sweep, defaults: release reset, apply `bin`=0..9, one value per cycle -> outputs one cycle later.
  - Digits 0–4: 0000001, 1001111, 0010010, 0000110, 1001100.
  - Digits 5–9: 0100100, 0100000, 0001111, 0000000, 0000100.
- Out-of-range, defaults: `bin`=10..15 -> `decimal`=1111110 for each code.
- `HEX_MODE`=1, `ACTIVE_LOW`=0: `bin`=10..15 -> 1110111, 0011111, 1001110, 0111101, 1001111, 1000111. Also check `bin`=0 -> 1111110.
- Latency/glitch: change `bin` from 3 to 7 mid-cycle and back to 3 before the edge -> `decimal` stays at digit 3 (0000110 in defaults). No change is visible until the edge, and only the sampled value appears.
- Reset mid-stream: while sweeping, assert `rst` for one edge at `bin`=5 -> blank for that cycle. The next edge with `bin`=6 shows 0100000.
